// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline execution controller and the debug unit.
package pipeline_ctrl_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

endpackage

// File: rtl/pipeline_step_ctrl_if.sv
// Command/status bundle between the debug unit, the pipeline and the step controller.
interface pipeline_step_ctrl_if #(
    parameter int BITS_SIZE = 32
);
    logic                 i_cmd_valid;
    logic [1:0]           i_cmd;
    logic [BITS_SIZE-1:0] i_cmd_arg;
    logic                 o_cmd_ready;
    logic                 i_halt;
    logic                 o_step;
    logic                 o_busy;
    logic                 o_halted;
    logic                 o_done;
    logic [BITS_SIZE-1:0] o_cycle_count;
    logic                 o_timeout;

    modport master (
        output i_cmd_valid, i_cmd, i_cmd_arg, i_halt,
        input  o_cmd_ready, o_step, o_busy, o_halted, o_done, o_cycle_count, o_timeout
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_cmd_arg, i_halt,
        output o_cmd_ready, o_step, o_busy, o_halted, o_done, o_cycle_count, o_timeout
    );
endinterface

// File: rtl/step_down_counter.sv
// Loadable down-counter; is_last flags the final count so the owner can stop on it.
module step_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             is_last
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign is_last = (count_reg == WIDTH'(1));
endmodule

// File: rtl/pipeline_step_ctrl.sv
// Step-enable controller for the five-stage pipeline (free-run / step N / stop, halt freeze).
// Optional RUN watchdog enabled by defining PIPELINE_STEP_CTRL_WATCHDOG_EN.
module pipeline_step_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int BITS_SIZE = 32
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
    , parameter logic [31:0] WATCHDOG_LIMIT = 32'd1000000
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pipeline_step_ctrl_if.slave  bus
);
    state_e               state_reg;
    logic                 done_reg;
    logic [BITS_SIZE-1:0] cycle_count_reg;
    logic                 active;
    logic                 step_en;
    logic                 cmd_fire;
    logic                 step_load;
    logic [BITS_SIZE-1:0] step_load_value;
    logic                 step_is_last;
    logic                 wd_is_last;

    assign active   = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    // Combinational so the pipeline freezes in the very cycle the halt reaches MEM/WB.
    assign step_en  = active && !bus.i_halt;
    assign cmd_fire = bus.i_cmd_valid && bus.o_cmd_ready;

    assign step_load       = (state_reg == ST_IDLE) && cmd_fire && (bus.i_cmd == CMD_STEP);
    assign step_load_value = (bus.i_cmd_arg == '0) ? BITS_SIZE'(1) : bus.i_cmd_arg;

    step_down_counter #(.WIDTH(BITS_SIZE)) u_step_cnt (
        .clk        (i_clk),
        .srst       (i_reset),
        .load       (step_load),
        .load_value (step_load_value),
        .dec        ((state_reg == ST_STEP) && step_en),
        .is_last    (step_is_last)
    );

`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
    logic timeout_reg;

    step_down_counter #(.WIDTH(BITS_SIZE)) u_wd_cnt (
        .clk        (i_clk),
        .srst       (i_reset),
        .load       ((state_reg == ST_IDLE) && cmd_fire && (bus.i_cmd == CMD_RUN)),
        .load_value (BITS_SIZE'(WATCHDOG_LIMIT)),
        .dec        ((state_reg == ST_RUN) && step_en),
        .is_last    (wd_is_last)
    );

    assign bus.o_timeout = timeout_reg;
`else
    assign wd_is_last    = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= ST_IDLE;
            done_reg        <= 1'b0;
            cycle_count_reg <= '0;
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
            timeout_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (step_en) begin
                cycle_count_reg <= cycle_count_reg + BITS_SIZE'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_fire && (bus.i_cmd == CMD_RUN)) begin
                        state_reg <= ST_RUN;
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
                        timeout_reg <= 1'b0;
`endif
                    end else if (cmd_fire && (bus.i_cmd == CMD_STEP)) begin
                        state_reg <= ST_STEP;
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
                        timeout_reg <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    // Halt outranks STOP and the watchdog in the same cycle.
                    if (bus.i_halt) begin
                        state_reg <= ST_HALTED;
                        done_reg  <= 1'b1;
                    end else if (cmd_fire && (bus.i_cmd == CMD_STOP)) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end else if (wd_is_last) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
                        timeout_reg <= 1'b1;
`endif
                    end
                end
                ST_STEP: begin
                    if (bus.i_halt) begin
                        state_reg <= ST_HALTED;
                        done_reg  <= 1'b1;
                    end else if (step_is_last) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_reg <= ST_HALTED;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready   = (state_reg != ST_STEP);
    assign bus.o_step        = step_en;
    assign bus.o_busy        = active;
    assign bus.o_halted      = (state_reg == ST_HALTED);
    assign bus.o_done        = done_reg;
    assign bus.o_cycle_count = cycle_count_reg;
endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Self-checking bench for pipeline_step_ctrl; exercises watchdog when PIPELINE_STEP_CTRL_WATCHDOG_EN is defined.
module tb_pipeline_step_ctrl;
    localparam int BW = 32;
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
    localparam int WD_LIMIT = 8;
    localparam int LONG_RUN = WD_LIMIT - 2;
    localparam int MAX_RAND_RUN = 5;
`else
    localparam int LONG_RUN = 10;
    localparam int MAX_RAND_RUN = 12;
`endif
    localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_STOP = 2'b11;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    logic [BW-1:0] exp_count = '0;

    pipeline_step_ctrl_if #(.BITS_SIZE(BW)) bus ();

    pipeline_step_ctrl #(
        .BITS_SIZE(BW)
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
        , .WATCHDOG_LIMIT(32'd8)
`endif
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd = C_NOP;
        bus.i_cmd_arg = '0;
        bus.i_halt = 1'b0;
        next_cycle();
        next_cycle();
        i_reset = 1'b0;
        exp_count = '0;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [BW-1:0] arg);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd = cmd;
        bus.i_cmd_arg = arg;
        next_cycle();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd = C_NOP;
        bus.i_cmd_arg = '0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge i_clk);
        n_checks++;
        if ({bus.o_step, bus.o_busy, bus.o_halted, bus.o_done, bus.o_timeout} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: step/busy/halted/done/timeout=%b required 00000",
                     {bus.o_step, bus.o_busy, bus.o_halted, bus.o_done, bus.o_timeout});
        end
        n_checks++;
        if (bus.o_cycle_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", bus.o_cycle_count);
        end
        n_checks++;
        if (bus.o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", bus.o_cmd_ready);
        end
        $display("test_reset done");
        next_cycle();
    endtask

    // STEP with the given argument: expect max(arg,1) step cycles then a done pulse.
    task automatic test_step(input logic [BW-1:0] arg);
        int n_exp;
        n_exp = (arg == 0) ? 1 : int'(arg);
        issue(C_STEP, arg);
        for (int c = 0; c < n_exp; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (bus.o_step !== 1'b1 || bus.o_cmd_ready !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL step_active arg=%0d c=%0d: step=%b ready=%b busy=%b done=%b required 1 0 1 0",
                         arg, c, bus.o_step, bus.o_cmd_ready, bus.o_busy, bus.o_done);
            end
            next_cycle();
        end
        exp_count = exp_count + BW'(n_exp);
        @(negedge i_clk);
        n_checks++;
        if (bus.o_step !== 1'b0 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL step_end arg=%0d: step=%b done=%b busy=%b ready=%b required 0 1 0 1",
                     arg, bus.o_step, bus.o_done, bus.o_busy, bus.o_cmd_ready);
        end
        n_checks++;
        if (bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL step_count arg=%0d: got %0d required %0d", arg, bus.o_cycle_count, exp_count);
        end
        next_cycle();
        @(negedge i_clk);
        n_checks++;
        if (bus.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL step_done_width arg=%0d: done=%b required 0", arg, bus.o_done);
        end
        $display("test_step arg=%0d steps=%0d count=%0d", arg, n_exp, bus.o_cycle_count);
        next_cycle();
    endtask

    task automatic test_run_halt(input int n);
        issue(C_RUN, '0);
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (bus.o_step !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL run_active c=%0d: step=%b busy=%b ready=%b required 1 1 1",
                         c, bus.o_step, bus.o_busy, bus.o_cmd_ready);
            end
            next_cycle();
        end
        exp_count = exp_count + BW'(n);
        bus.i_halt = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (bus.o_step !== 1'b0) begin
            n_fail++;
            $display("FAIL run_halt_freeze: step=%b required 0", bus.o_step);
        end
        next_cycle();
        @(negedge i_clk);
        n_checks++;
        if (bus.o_halted !== 1'b1 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL run_halted: halted=%b done=%b busy=%b count=%0d required 1 1 0 %0d",
                     bus.o_halted, bus.o_done, bus.o_busy, bus.o_cycle_count, exp_count);
        end
        next_cycle();
        bus.i_halt = 1'b0;
        issue(C_RUN, '0);
        issue(C_STEP, BW'(5));
        @(negedge i_clk);
        n_checks++;
        if (bus.o_step !== 1'b0 || bus.o_halted !== 1'b1 || bus.o_done !== 1'b0 || bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL halted_sticky: step=%b halted=%b done=%b count=%0d required 0 1 0 %0d",
                     bus.o_step, bus.o_halted, bus.o_done, bus.o_cycle_count, exp_count);
        end
        $display("test_run_halt n=%0d count=%0d halted=%b", n, bus.o_cycle_count, bus.o_halted);
        do_reset();
    endtask

    // RUN for n cycles, then STOP; the STOP cycle itself still steps.
    task automatic test_run_stop(input int n);
        issue(C_RUN, '0);
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (bus.o_step !== 1'b1) begin
                n_fail++;
                $display("FAIL runstop_active n=%0d c=%0d: step=%b required 1", n, c, bus.o_step);
            end
            next_cycle();
        end
        issue(C_STOP, '0);
        exp_count = exp_count + BW'(n + 1);
        @(negedge i_clk);
        n_checks++;
        if (bus.o_step !== 1'b0 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_halted !== 1'b0 || bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL runstop_end n=%0d: step=%b done=%b busy=%b halted=%b count=%0d required 0 1 0 0 %0d",
                     n, bus.o_step, bus.o_done, bus.o_busy, bus.o_halted, bus.o_cycle_count, exp_count);
        end
        $display("test_run_stop n=%0d count=%0d", n, bus.o_cycle_count);
        next_cycle();
    endtask

    task automatic test_stop_halt_same();
        issue(C_RUN, '0);
        for (int c = 0; c < 5; c++) next_cycle();
        exp_count = exp_count + BW'(5);
        bus.i_halt = 1'b1;
        issue(C_STOP, '0);
        @(negedge i_clk);
        n_checks++;
        if (bus.o_halted !== 1'b1 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL stop_halt_priority: halted=%b done=%b busy=%b count=%0d required 1 1 0 %0d",
                     bus.o_halted, bus.o_done, bus.o_busy, bus.o_cycle_count, exp_count);
        end
        next_cycle();
        bus.i_halt = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (bus.o_done !== 1'b0 || bus.o_halted !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_halt_pulse: done=%b halted=%b required 0 1", bus.o_done, bus.o_halted);
        end
        $display("test_stop_halt_same halted=%b", bus.o_halted);
        do_reset();
    endtask

    task automatic test_reset_mid_step();
        issue(C_STEP, BW'(4));
        next_cycle();
        next_cycle();
        i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0;
        exp_count = '0;
        @(negedge i_clk);
        n_checks++;
        if ({bus.o_step, bus.o_busy, bus.o_halted, bus.o_done, bus.o_timeout} !== 5'b0 || bus.o_cycle_count !== '0 || bus.o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_step: step/busy/halted/done/timeout=%b count=%0d ready=%b required 00000 0 1",
                     {bus.o_step, bus.o_busy, bus.o_halted, bus.o_done, bus.o_timeout}, bus.o_cycle_count, bus.o_cmd_ready);
        end
        $display("test_reset_mid_step count=%0d", bus.o_cycle_count);
        next_cycle();
    endtask

    task automatic test_random_mix();
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 0) test_step(BW'($urandom_range(0, 12)));
            else test_run_stop(int'($urandom_range(0, MAX_RAND_RUN)));
        end
    endtask

`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        issue(C_RUN, '0);
        for (int c = 0; c < WD_LIMIT; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (bus.o_step !== 1'b1 || bus.o_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_run c=%0d: step=%b timeout=%b required 1 0", c, bus.o_step, bus.o_timeout);
            end
            next_cycle();
        end
        exp_count = exp_count + BW'(WD_LIMIT);
        @(negedge i_clk);
        n_checks++;
        if (bus.o_step !== 1'b0 || bus.o_timeout !== 1'b1 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL wd_trip: step=%b timeout=%b done=%b busy=%b count=%0d required 0 1 1 0 %0d",
                     bus.o_step, bus.o_timeout, bus.o_done, bus.o_busy, bus.o_cycle_count, exp_count);
        end
        next_cycle();
        @(negedge i_clk);
        n_checks++;
        if (bus.o_done !== 1'b0 || bus.o_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_hold: done=%b timeout=%b required 0 1", bus.o_done, bus.o_timeout);
        end
        next_cycle();
        issue(C_RUN, '0);
        @(negedge i_clk);
        n_checks++;
        if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_clear: timeout=%b busy=%b required 0 1", bus.o_timeout, bus.o_busy);
        end
        next_cycle();
        issue(C_STOP, '0);
        exp_count = exp_count + BW'(2);
        @(negedge i_clk);
        n_checks++;
        if (bus.o_done !== 1'b1 || bus.o_cycle_count !== exp_count) begin
            n_fail++;
            $display("FAIL wd_restop: done=%b count=%0d required 1 %0d", bus.o_done, bus.o_cycle_count, exp_count);
        end
        $display("test_watchdog count=%0d", bus.o_cycle_count);
        next_cycle();
    endtask
`endif

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd = C_NOP;
        bus.i_cmd_arg = '0;
        bus.i_halt = 1'b0;
        test_reset();
        test_step(BW'(3));
        test_step(BW'(0));
        test_run_halt(LONG_RUN);
        test_reset_mid_step();
        test_random_mix();
        test_stop_halt_same();
`ifdef PIPELINE_STEP_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_step_ctrl.md
Name: pipeline_step_ctrl

Overview:
Execution controller for the five-stage MIPS pipeline. It produces the single step-enable that every pipeline register (IFID, IDEX, EXMEM, MEMWB) and the PC sample. Commands come from the debug unit: free-run, step N cycles, or stop. The block freezes the pipeline when the halt flag reaches the MEM/WB output and counts executed cycles for readback.

Parameters:
BITS_SIZE, 32, width of the cycle counter and of the step-count argument
WATCHDOG_LIMIT, 32'd1000000, maximum RUN cycles before forced stop (only used with the watchdog feature)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command strobe from debug unit
i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 STOP
i_cmd_arg  in  BITS_SIZE  step count for STEP; 0 is treated as 1
o_cmd_ready  out  1  command accepted when valid & ready
i_halt  in  1  halt flag from MEMWB o_halt
o_step  out  1  pipeline advance enable (drives every i_step)
o_busy  out  1  state is RUN or STEP
o_halted  out  1  state is HALTED
o_done  out  1  one-cycle pulse when a STEP/RUN sequence ends
o_cycle_count  out  BITS_SIZE  number of cycles with o_step=1 since reset
o_timeout  out  1  watchdog tripped (tied 0 without the feature)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values: state IDLE, o_step=0, o_busy=0, o_halted=0, o_done=0, o_cycle_count=0, o_timeout=0, step counter=0. A reset asserted mid-RUN or mid-STEP takes effect on that edge; o_step is 0 in the following cycle.
- States: IDLE, RUN, STEP, HALTED.
- o_cmd_ready: 1 in IDLE and RUN, 0 in STEP, 1 in HALTED (commands are swallowed there).
- IDLE:
  - RUN accepted -> RUN.
  - STEP accepted -> load remaining = (arg==0 ? 1 : arg), go to STEP.
  - NOP and STOP are accepted and ignored.
- RUN:
  - o_step = ~i_halt, combinational, so the pipeline freezes in the same cycle the halt reaches MEM/WB.
  - i_halt=1 -> HALTED and pulse o_done.
  - STOP accepted -> IDLE and pulse o_done; the STOP cycle itself still has o_step=~i_halt.
  - RUN and STEP are ignored while in RUN.
  - Halt takes priority over STOP when both occur in the same cycle.
- STEP:
  - o_step = ~i_halt.
  - Each cycle with o_step=1 decrements remaining.
  - When remaining==1 and o_step=1 -> IDLE and pulse o_done.
  - i_halt=1 -> HALTED and pulse o_done; remaining is discarded.
- HALTED: o_step=0 and o_halted=1. The only exit is i_reset.
- Latency: a command accepted at edge t produces its first o_step=1 in the cycle after t. STEP with arg N yields exactly N cycles of o_step=1 unless a halt intervenes.
- o_done: registered, high for 1 cycle, in the cycle after the last o_step.
- o_cycle_count: increments on every edge where o_step=1 and wraps modulo 2^BITS_SIZE without saturation.
- o_busy: 1 exactly when the state is RUN or STEP.

Optional Feature:
Macro PIPELINE_STEP_CTRL_WATCHDOG_EN.
- Defined: a RUN-length counter clears on entry to RUN. When it reaches WATCHDOG_LIMIT with no halt, o_step is forced to 0, o_timeout is set, o_done pulses, and the state becomes IDLE. o_timeout stays set until reset or the next accepted RUN/STEP.
- Undefined: no counter is built, o_timeout is tied to 0, and RUN is unbounded.

Decomposition:
- Package pipeline_ctrl_pkg holds the command encodings (CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP) and the state enum (ST_IDLE, ST_RUN, ST_STEP, ST_HALTED). The debug unit shares this package.
- One sub-module, step_down_counter: load/decrement with an is_last flag, used for the remaining-step count and reused for the watchdog.

Test Plan:
1. Reset, then STEP arg=3 -> o_step high for exactly 3 cycles starting 1 cycle after acceptance; o_done pulses next cycle; o_cycle_count=3; o_cmd_ready=0 throughout.
2. STEP arg=0 -> exactly 1 o_step cycle; o_cycle_count increments by 1.
3. RUN, assert i_halt after 10 stepped cycles -> o_step=0 in the same cycle as i_halt; o_halted=1 next cycle; o_cycle_count=10; a later RUN/STEP gives no o_step.
4. RUN, then STOP at cycle 5 while i_halt=1 in the same cycle -> state HALTED (halt wins), o_done single pulse.
5. STEP arg=4, reset asserted after the 2nd o_step -> all outputs at reset values next cycle; o_cycle_count=0.
6. With watchdog, WATCHDOG_LIMIT=8: RUN, no halt -> exactly 8 o_step cycles, o_timeout=1, o_done pulse, state IDLE; a new RUN clears o_timeout.
